// File: rtl/bsg_word_serializer_pkg.sv
// Shared definitions for bsg_word_serializer.
// Define BSG_WORD_SERIALIZER_MSB_FIRST_EN to emit the most significant chunk first.
package bsg_word_serializer_pkg;

    function automatic int ctr_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

`ifdef BSG_WORD_SERIALIZER_MSB_FIRST_EN
    localparam bit chunk_msb_first_lp = 1'b1;
`else
    localparam bit chunk_msb_first_lp = 1'b0;
`endif

endpackage

// File: rtl/bsg_word_serializer_if.sv
// Word-in / chunk-out handshake bundle; slave is the serializer, master drives it.
interface bsg_word_serializer_if #(
    parameter int width_p = 8,
    parameter int els_p   = 4
);
    logic [width_p*els_p-1:0] data_i;
    logic                     v_i;
    logic                     yumi_o;
    logic [width_p-1:0]       data_o;
    logic                     v_o;
    logic                     last_o;
    logic                     ready_i;

    modport slave  (input  data_i, v_i, ready_i, output yumi_o, data_o, v_o, last_o);
    modport master (output data_i, v_i, ready_i, input  yumi_o, data_o, v_o, last_o);
endinterface

// File: rtl/bsg_word_serializer_ctr.sv
// Chunk index counter: clear wins over increment, last_o flags index els_p-1.
module bsg_word_serializer_ctr
    import bsg_word_serializer_pkg::*;
#(
    parameter int els_p       = 4,
    parameter int cnt_width_p = ctr_width(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   incr_i,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   last_o
);
    logic [cnt_width_p-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (incr_i) cnt_d = cnt_q + 1'b1;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == cnt_width_p'(els_p - 1));
endmodule

// File: rtl/bsg_word_serializer.sv
// Parallel-in/serial-out converter: valid/yumi word input, ready/valid chunk output.
// Chunk order selected by BSG_WORD_SERIALIZER_MSB_FIRST_EN (default LSB first).
module bsg_word_serializer
    import bsg_word_serializer_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_word_serializer_if.slave   ser
);
    localparam int cnt_w_lp = ctr_width(els_p);

    logic                     full_q, full_d;
    logic [width_p*els_p-1:0] data_q, data_d;
    logic [cnt_w_lp-1:0]      cnt;
    logic [cnt_w_lp-1:0]      sel;
    logic                     last, xfer, accept;

    // Accept is allowed in the same cycle the final chunk leaves, so words run back to back.
    assign xfer   = full_q & ser.ready_i;
    assign accept = ser.v_i & ~reset_i & (~full_q | (xfer & last));

    bsg_word_serializer_ctr #(
        .els_p      (els_p),
        .cnt_width_p(cnt_w_lp)
    ) u_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(accept | (xfer & last)),
        .incr_i (xfer & ~last),
        .cnt_o  (cnt),
        .last_o (last)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = ser.data_i;
        end else if (xfer && last) begin
            full_d = 1'b0;
        end
    end

    always_comb begin
        if (chunk_msb_first_lp) sel = cnt_w_lp'(els_p - 1) - cnt;
        else                    sel = cnt;
        ser.yumi_o = accept;
        ser.v_o    = full_q;
        ser.last_o = last;
        ser.data_o = '0;
        for (int unsigned i = 0; i < els_p; i++) begin
            if (sel == cnt_w_lp'(i)) ser.data_o = data_q[i*width_p +: width_p];
        end
    end
endmodule

// File: tb/tb_bsg_word_serializer.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_bsg_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_word_serializer_if #(.width_p(8),  .els_p(4)) a_if ();
    bsg_word_serializer_if #(.width_p(32), .els_p(1)) b_if ();

    bsg_word_serializer #(.width_p(8), .els_p(4)) u_dut_a (
        .clk_i(clk), .reset_i(rst), .ser(a_if)
    );
    bsg_word_serializer #(.width_p(32), .els_p(1)) u_dut_b (
        .clk_i(clk), .reset_i(rst), .ser(b_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  qa[$];   // chunks of the held word still to be sent
    logic        b_full;
    logic [31:0] b_word;

    function automatic logic exp_yumi_a();
        return a_if.v_i && !rst && (qa.size() == 0 || (a_if.ready_i && qa.size() == 1));
    endfunction

    function automatic logic exp_yumi_b();
        return b_if.v_i && !rst && (!b_full || b_if.ready_i);
    endfunction

    initial begin
        logic ya, yb;
        b_full = 1'b0;
        b_word = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qa.delete();
                b_full = 1'b0;
            end else begin
                ya = exp_yumi_a();
                yb = exp_yumi_b();
                if (qa.size() > 0 && a_if.ready_i) void'(qa.pop_front());
                if (ya) begin
                    for (int k = 0; k < 4; k++) begin
`ifdef BSG_WORD_SERIALIZER_MSB_FIRST_EN
                        qa.push_back(a_if.data_i[(3-k)*8 +: 8]);
`else
                        qa.push_back(a_if.data_i[k*8 +: 8]);
`endif
                    end
                end
                if (yb) begin
                    b_full = 1'b1;
                    b_word = b_if.data_i;
                end else if (b_full && b_if.ready_i) begin
                    b_full = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_a_v", a_if.v_o, qa.size() > 0);
            chk("m_a_yumi", a_if.yumi_o, exp_yumi_a());
            if (qa.size() > 0) begin
                chk("m_a_data", a_if.data_o, qa[0]);
                chk("m_a_last", a_if.last_o, qa.size() == 1);
            end
            chk("m_b_v", b_if.v_o, b_full);
            chk("m_b_yumi", b_if.yumi_o, exp_yumi_b());
            chk("m_b_last", b_if.last_o, 1);
            if (b_full) chk("m_b_data", b_if.data_o, b_word);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] o1 [4];
    logic [7:0] o2 [8];
    logic [7:0] o4 [4];
    logic [39:0] vpat;
    logic [39:0] rpat;

    initial begin
`ifdef BSG_WORD_SERIALIZER_MSB_FIRST_EN
        o1 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        o2 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        o4 = '{8'h0F, 8'h0E, 8'h0D, 8'h0C};
`else
        o1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        o2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        o4 = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};
`endif
        vpat = 40'hF3_7A_C5_FF_1E;
        rpat = 40'hBD_6F_F9_A7_DB;

        a_if.v_i = 1'b1; a_if.data_i = 32'h12345678; a_if.ready_i = 1'b1;
        b_if.v_i = 1'b0; b_if.data_i = '0;           b_if.ready_i = 1'b1;
        #1;
        chk("rst_v", a_if.v_o, 0);
        chk("rst_last", a_if.last_o, 0);
        chk("rst_data", a_if.data_o, 0);
        chk("rst_yumi", a_if.yumi_o, 0);
        tick(); tick();
        rst = 1'b0; a_if.v_i = 1'b0;
        tick();

        // single word
        a_if.v_i = 1'b1; a_if.data_i = 32'hDDCCBBAA;
        @(negedge clk); chk("t1_yumi", a_if.yumi_o, 1);
        tick(); a_if.v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_data", a_if.data_o, o1[i]);
            chk("t1_last", a_if.last_o, i == 3);
            chk("t1_v", a_if.v_o, 1);
            tick();
        end
        @(negedge clk); chk("t1_idle", a_if.v_o, 0);
        tick();

        // back-to-back words
        a_if.v_i = 1'b1; a_if.data_i = 32'h44332211;
        @(negedge clk); chk("t2_yumi0", a_if.yumi_o, 1);
        tick(); a_if.data_i = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_data", a_if.data_o, o2[i]);
            chk("t2_v", a_if.v_o, 1);
            chk("t2_yumi", a_if.yumi_o, i == 3);
            tick();
            if (i == 3) a_if.v_i = 1'b0;
        end
        @(negedge clk); chk("t2_idle", a_if.v_o, 0);
        tick();

        // backpressure
        a_if.v_i = 1'b1; a_if.data_i = 32'hDDCCBBAA;
        @(negedge clk); chk("t3_yumi", a_if.yumi_o, 1);
        tick(); a_if.v_i = 1'b0;
        @(negedge clk); chk("t3_c0", a_if.data_o, o1[0]);
        tick(); a_if.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_data", a_if.data_o, o1[1]);
            chk("t3_hold_v", a_if.v_o, 1);
            chk("t3_hold_yumi", a_if.yumi_o, 0);
            tick();
        end
        a_if.ready_i = 1'b1;
        @(negedge clk); chk("t3_c1", a_if.data_o, o1[1]);
        tick();
        @(negedge clk); chk("t3_c2", a_if.data_o, o1[2]);
        tick();
        @(negedge clk); chk("t3_c3", a_if.data_o, o1[3]);
        tick();
        @(negedge clk); chk("t3_idle", a_if.v_o, 0);
        tick();

        // reset mid-word
        a_if.v_i = 1'b1; a_if.data_i = 32'hDDCCBBAA;
        @(negedge clk); chk("t4_yumi", a_if.yumi_o, 1);
        tick(); a_if.v_i = 1'b0;
        tick(); tick();
        rst = 1'b1; a_if.v_i = 1'b1; a_if.data_i = 32'h0F0E0D0C;
        #1;
        chk("t4_rst_v", a_if.v_o, 0);
        chk("t4_rst_yumi", a_if.yumi_o, 0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("t4_yumi2", a_if.yumi_o, 1);
        tick(); a_if.v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_data", a_if.data_o, o4[i]);
            tick();
        end
        @(negedge clk); chk("t4_idle", a_if.v_o, 0);
        tick();

        // els_p = 1 pipe register
        b_if.v_i = 1'b1; b_if.data_i = 32'd1;
        @(negedge clk);
        chk("t5_yumi1", b_if.yumi_o, 1);
        chk("t5_v0", b_if.v_o, 0);
        tick(); b_if.data_i = 32'd2;
        @(negedge clk);
        chk("t5_d1", b_if.data_o, 1);
        chk("t5_yumi2", b_if.yumi_o, 1);
        chk("t5_last", b_if.last_o, 1);
        tick(); b_if.data_i = 32'd3;
        @(negedge clk); chk("t5_d2", b_if.data_o, 2);
        tick(); b_if.v_i = 1'b0;
        @(negedge clk);
        chk("t5_d3", b_if.data_o, 3);
        chk("t5_yumi_off", b_if.yumi_o, 0);
        tick();
        @(negedge clk); chk("t5_idle", b_if.v_o, 0);
        tick();

        // mixed valid/ready patterns, checked by the model
        for (int i = 0; i < 40; i++) begin
            a_if.v_i     = vpat[i];
            a_if.ready_i = rpat[i];
            a_if.data_i  = 32'(i) * 32'h01010101 + 32'h10203040;
            b_if.v_i     = rpat[39-i];
            b_if.ready_i = vpat[39-i];
            b_if.data_i  = 32'hA5000000 + 32'(i);
            tick();
        end
        a_if.v_i = 1'b0; a_if.ready_i = 1'b1;
        b_if.v_i = 1'b0; b_if.ready_i = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("end_a_idle", a_if.v_o, 0);
        chk("end_b_idle", b_if.v_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_word_serializer.md
Name: bsg_word_serializer

Overview:
- Parallel-in/serial-out converter. Pulls full words from an upstream valid/yumi producer and emits them as narrow chunks on a ready-and-valid output.
- Sits at the output of one-element FIFOs and other valid/yumi sources that feed narrow links, e.g. off-chip or network flit channels.
- It is the consumer end of the valid/yumi handshake: this block generates yumi; it does not receive it.

Parameters:
- width_p, 8, width of one output chunk in bits.
- els_p, 4, chunks per input word; input word width is width_p*els_p. Legal values are 1 or more.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- data_i  in  width_p*els_p  input word; sampled only in a cycle where yumi_o=1.
- v_i  in  1  upstream word valid.
- yumi_o  out  1  word accepted this cycle. Combinational; asserted only when v_i=1.
- data_o  out  width_p  current chunk.
- v_o  out  1  chunk valid.
- last_o  out  1  current chunk is the final chunk of its word; meaningful only while v_o=1.
- ready_i  in  1  downstream ready; an output transfer occurs when v_o and ready_i are both 1.

Behaviour:
- State registers:
  - full_r (1 bit): word held.
  - cnt_r (max(1,$clog2(els_p)) bits): chunk index.
  - data_r (width_p*els_p bits): held word.
- Reset (async assert; deassert is synchronous to clk_i): full_r=0, cnt_r=0, data_r=0.
  - Hence v_o=0, last_o=0 (when els_p>1), data_o=0.
  - yumi_o is forced to 0 while reset_i=1.
- Outputs:
  - v_o = full_r.
  - data_o = data_r[cnt_r*width_p +: width_p]; LSB chunk first by default.
  - last_o = (cnt_r == els_p-1).
- Transfer: xfer = v_o & ready_i.
- Accept: yumi_o = v_i & ~reset_i & (~full_r | (xfer & last_o)).
  - An empty block accepts in the same cycle v_i rises.
  - A new word is also accepted in the same cycle the last chunk drains, giving zero bubbles.
- Per posedge:
  - If yumi_o: data_r<=data_i, full_r<=1, cnt_r<=0.
  - Else if xfer & last_o: full_r<=0, cnt_r<=0.
  - Else if xfer: cnt_r<=cnt_r+1.
  - Otherwise hold all state.
- Latency: the first chunk of an accepted word appears on data_o the cycle after yumi_o.
- Throughput: one chunk per cycle under continuous ready_i and v_i. Sustained word rate is 1/els_p.
- Backpressure: with ready_i=0, data_o, last_o and cnt_r hold; v_o stays 1 (no valid retraction).
- cnt_r never exceeds els_p-1 and wraps to 0 only via the last-chunk transfer.
- els_p=1: last_o is constant 1 and the block behaves as a one-word pipe register. Accept and drain can occur in the same cycle.
- Reset mid-word: the partial word is discarded and the next accepted word starts at chunk 0.
- ready_i may toggle freely; v_i may drop without yumi_o (no obligation on the upstream side).

Optional Feature:
- Macro: BSG_WORD_SERIALIZER_MSB_FIRST_EN.
- Defined: chunk order is reversed, data_o = data_r[(els_p-1-cnt_r)*width_p +: width_p]; last_o still marks the final chunk sent.
- Undefined: LSB chunk first, as described above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package bsg_word_serializer_pkg:
  - Function computing the counter width, max(1,$clog2(els_p)).
  - Localparam for the default chunk order.
  - No enum; full_r is the whole state machine (EMPTY/BUSY).
- One natural sub-module, bsg_word_serializer_ctr: chunk counter with async reset, clear, increment enable and a last-flag output.
- The datapath mux stays in the top module.

Test Plan:
- Single word (width_p=8, els_p=4): data_i=0xDDCCBBAA with v_i pulsed one cycle and ready_i=1 → yumi_o=1 that cycle; data_o = AA, BB, CC, DD on the next 4 cycles; last_o=1 only on DD; v_o=0 afterwards.
- Back-to-back words: 0x44332211 then 0x88776655, v_i and ready_i held 1 → 8 consecutive chunks 11..88 with no v_o gap. yumi_o is asserted at t0 and at t4, the cycle chunk 44 transfers.
- Backpressure: ready_i=0 for 3 cycles while data_o=BB → data_o=BB, v_o=1, yumi_o=0 throughout; CC follows on the first cycle after ready_i returns to 1.
- Reset mid-word: assert reset_i after chunk BB transfers → v_o=0 immediately (async), yumi_o=0. Next word 0x0F0E0D0C after reset starts with 0C.
- Edge config, width_p=32, els_p=1: v_i=1 continuous with values 1, 2, 3 and ready_i=1 → one word per cycle, last_o=1 always, 1-cycle latency.
- Macro defined (width_p=8, els_p=4): 0xDDCCBBAA → DD, CC, BB, AA, with last_o=1 on AA.
